ctrl_pipe: RTL and testbench

Control-signal pipeline for the 5-stage MIPS pipeline. Takes the decoded control word and register specifiers produced in the Decode stage and carries them through the ID/EX, EX/MEM and MEM/WB boundaries, delivering per-stage control to the datapath. Handles bubble insertion, flush and stall, resolves the destination register in Execute, and counts retired instructions.

---
 rtl/ctrl_pipe.sv | 147 ++++++++++++++
 tb/tb_ctrl_pipe.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - control-signal pipeline carrying decoded control through ID/EX, EX/MEM, MEM/WB
// Handles bubble insertion, flush, two stall levels and counts retired instructions.
module ctrl_pipe #(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ValidD,
  input  logic                RegWriteD,
  input  logic                MemtoRegD,
  input  logic                MemWriteD,
  input  logic                ALUSrcD,
  input  logic                RegDstD,
  input  logic                ALUSelectShilfD,
  input  logic [3:0]          ALUCtrlD,
  input  logic [4:0]          RsD,
  input  logic [4:0]          RtD,
  input  logic [4:0]          RdD,
  input  logic                FlushE,
  input  logic                StallE,
  input  logic                StallM,
  output logic                ValidE,
  output logic                RegWriteE,
  output logic                MemtoRegE,
  output logic                MemWriteE,
  output logic                ALUSrcE,
  output logic                ALUSelectShilfE,
  output logic [3:0]          ALUCtrlE,
  output logic [4:0]          RsE,
  output logic [4:0]          RtE,
  output logic [4:0]          WriteRegE,
  output logic                ValidM,
  output logic                RegWriteM,
  output logic                MemtoRegM,
  output logic                MemWriteM,
  output logic [4:0]          WriteRegM,
  output logic                ValidW,
  output logic                RegWriteW,
  output logic                MemtoRegW,
  output logic [4:0]          WriteRegW,
  output logic [RETIRE_W-1:0] RetireCount
);

  localparam logic [RETIRE_W-1:0] RETIRE_ONE = RETIRE_W'(1);

  logic       reg_dst_e;
  logic [4:0] rd_e;

  assign WriteRegE = reg_dst_e ? rd_e : RtE;

  // Stage E: holds under either stall; an invalid Decode slot is never trusted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ValidE          <= 1'b0;
      RegWriteE       <= 1'b0;
      MemtoRegE       <= 1'b0;
      MemWriteE       <= 1'b0;
      ALUSrcE         <= 1'b0;
      reg_dst_e       <= 1'b0;
      ALUSelectShilfE <= 1'b0;
      ALUCtrlE        <= 4'd0;
      RsE             <= 5'd0;
      RtE             <= 5'd0;
      rd_e            <= 5'd0;
    end else if (StallM || StallE) begin
      ValidE <= ValidE;
    end else if (FlushE || !ValidD) begin
      ValidE          <= 1'b0;
      RegWriteE       <= 1'b0;
      MemtoRegE       <= 1'b0;
      MemWriteE       <= 1'b0;
      ALUSrcE         <= 1'b0;
      reg_dst_e       <= 1'b0;
      ALUSelectShilfE <= 1'b0;
      ALUCtrlE        <= 4'd0;
      RsE             <= 5'd0;
      RtE             <= 5'd0;
      rd_e            <= 5'd0;
    end else begin
      ValidE          <= 1'b1;
      RegWriteE       <= RegWriteD;
      MemtoRegE       <= MemtoRegD;
      MemWriteE       <= MemWriteD;
      ALUSrcE         <= ALUSrcD;
      reg_dst_e       <= RegDstD;
      ALUSelectShilfE <= ALUSelectShilfD;
      ALUCtrlE        <= ALUCtrlD;
      RsE             <= RsD;
      RtE             <= RtD;
      rd_e            <= RdD;
    end
  end

  // Stage M: a held E produces a bubble here rather than a duplicate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ValidM    <= 1'b0;
      RegWriteM <= 1'b0;
      MemtoRegM <= 1'b0;
      MemWriteM <= 1'b0;
      WriteRegM <= 5'd0;
    end else if (StallM) begin
      ValidM <= ValidM;
    end else if (StallE) begin
      ValidM    <= 1'b0;
      RegWriteM <= 1'b0;
      MemtoRegM <= 1'b0;
      MemWriteM <= 1'b0;
      WriteRegM <= 5'd0;
    end else begin
      ValidM    <= ValidE;
      RegWriteM <= RegWriteE;
      MemtoRegM <= MemtoRegE;
      MemWriteM <= MemWriteE;
      WriteRegM <= WriteRegE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ValidW    <= 1'b0;
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
      WriteRegW <= 5'd0;
    end else if (StallM) begin
      ValidW    <= 1'b0;
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
      WriteRegW <= 5'd0;
    end else begin
      ValidW    <= ValidM;
      RegWriteW <= RegWriteM;
      MemtoRegW <= MemtoRegM;
      WriteRegW <= WriteRegM;
    end
  end

  // Counts the instruction leaving W; W never holds so each is seen once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RetireCount <= '0;
    end else if (ValidW) begin
      RetireCount <= RetireCount + RETIRE_ONE;
    end
  end

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb/tb_ctrl_pipe.sv - self-checking bench for ctrl_pipe
// Scoreboard of expected W-stage records plus directed stage checks.
module tb_ctrl_pipe;

  localparam int RW = 4;

  logic clk = 1'b0;
  logic reset;
  logic ValidD, RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, ALUSelectShilfD;
  logic [3:0] ALUCtrlD;
  logic [4:0] RsD, RtD, RdD;
  logic FlushE, StallE, StallM;
  logic ValidE, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, ALUSelectShilfE;
  logic [3:0] ALUCtrlE;
  logic [4:0] RsE, RtE, WriteRegE;
  logic ValidM, RegWriteM, MemtoRegM, MemWriteM;
  logic [4:0] WriteRegM;
  logic ValidW, RegWriteW, MemtoRegW;
  logic [4:0] WriteRegW;
  logic [RW-1:0] RetireCount;

  int checks = 0;
  int failures = 0;
  logic [6:0] sb[$];
  logic [6:0] sb_exp;

  ctrl_pipe #(.RETIRE_W(RW)) dut (
    .clk(clk), .reset(reset),
    .ValidD(ValidD), .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
    .ALUSrcD(ALUSrcD), .RegDstD(RegDstD), .ALUSelectShilfD(ALUSelectShilfD),
    .ALUCtrlD(ALUCtrlD), .RsD(RsD), .RtD(RtD), .RdD(RdD),
    .FlushE(FlushE), .StallE(StallE), .StallM(StallM),
    .ValidE(ValidE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .ALUSrcE(ALUSrcE), .ALUSelectShilfE(ALUSelectShilfE), .ALUCtrlE(ALUCtrlE),
    .RsE(RsE), .RtE(RtE), .WriteRegE(WriteRegE),
    .ValidM(ValidM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .WriteRegM(WriteRegM),
    .ValidW(ValidW), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .WriteRegW(WriteRegW),
    .RetireCount(RetireCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] e_vec();
    return 64'({ValidE, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, ALUSelectShilfE,
                ALUCtrlE, RsE, RtE, WriteRegE});
  endfunction

  function automatic logic [63:0] mk_e(input logic v, rw, m2r, mw, src, shf,
                                       input logic [3:0] ctrl, input logic [4:0] rs, rt, wr);
    return 64'({v, rw, m2r, mw, src, shf, ctrl, rs, rt, wr});
  endfunction

  function automatic logic [63:0] all_out();
    return 64'({e_vec(), ValidM, RegWriteM, MemtoRegM, MemWriteM, WriteRegM,
                ValidW, RegWriteW, MemtoRegW, WriteRegW, RetireCount});
  endfunction

  task automatic drive_d(input logic v, rw, m2r, mw, src, dst, shf,
                         input logic [3:0] ctrl, input logic [4:0] rs, rt, rd);
    ValidD = v; RegWriteD = rw; MemtoRegD = m2r; MemWriteD = mw; ALUSrcD = src;
    RegDstD = dst; ALUSelectShilfD = shf; ALUCtrlD = ctrl; RsD = rs; RtD = rt; RdD = rd;
  endtask

  task automatic idle_d();
    drive_d(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 5'd0, 5'd0, 5'd0);
  endtask

  // An instruction is accepted into E only on an unstalled, unflushed edge.
  task automatic tick();
    if (ValidD && !StallM && !StallE && !FlushE)
      sb.push_back({RegWriteD, MemtoRegD, (RegDstD ? RdD : RtD)});
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    if (!reset && ValidW) begin
      if (sb.size() == 0) begin
        check("sb_extra", 64'(ValidW), 64'd0);
      end else begin
        sb_exp = sb.pop_front();
        check("sb_w", 64'({RegWriteW, MemtoRegW, WriteRegW}), 64'(sb_exp));
      end
    end
  end

  initial begin
    reset = 1'b1; FlushE = 1'b0; StallE = 1'b0; StallM = 1'b0;
    idle_d();
    tick(); tick();
    check("reset_all", all_out(), 64'd0);
    reset = 1'b0;

    // Stream of four add-type instructions.
    for (int i = 0; i < 4; i++) begin
      drive_d(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 5'(i), 5'(20 + i), 5'(8 + i));
      tick();
      if (i == 0) check("stream_e0", e_vec(), mk_e(1, 1, 0, 0, 0, 0, 4'd2, 5'd0, 5'd20, 5'd8));
    end
    idle_d();
    repeat (4) tick();
    check("stream_retire", 64'(RetireCount), 64'd4);

    // lw flushed on entry never reaches W.
    drive_d(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 5'd1, 5'd5, 5'd0);
    FlushE = 1'b1;
    tick();
    FlushE = 1'b0;
    idle_d();
    check("flush_e", 64'({ValidE, RegWriteE, WriteRegE}), 64'd0);
    repeat (3) tick();
    check("flush_retire", 64'(RetireCount), 64'd4);

    // sw held in E for two cycles.
    drive_d(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 5'd2, 5'd3, 5'd7);
    tick();
    idle_d();
    StallE = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("stalle_e", e_vec(), mk_e(1, 0, 0, 1, 1, 0, 4'd2, 5'd2, 5'd3, 5'd3));
      check("stalle_m", 64'({ValidM, MemWriteM}), 64'd0);
    end
    StallE = 1'b0;
    tick();
    check("stalle_rel_m", 64'({ValidM, MemWriteM, WriteRegM}), 64'({2'b11, 5'd3}));
    tick();
    check("stalle_once", 64'({ValidM, MemWriteM}), 64'd0);
    repeat (2) tick();
    check("stalle_retire", 64'(RetireCount), 64'd5);

    // StallM dominates StallE and FlushE.
    drive_d(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 5'd1, 5'd2, 5'd12);
    tick();
    drive_d(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd4, 5'd3, 5'd4, 5'd13);
    tick();
    idle_d();
    StallM = 1'b1; StallE = 1'b1; FlushE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stallm_w", 64'(ValidW), 64'd0);
      check("stallm_e", 64'({ValidE, WriteRegE}), 64'({1'b1, 5'd13}));
      check("stallm_m", 64'({ValidM, WriteRegM}), 64'({1'b1, 5'd12}));
    end
    StallM = 1'b0; StallE = 1'b0; FlushE = 1'b0;
    repeat (4) tick();
    check("stallm_retire", 64'(RetireCount), 64'd7);

    // Invalid decode slot with every control line high.
    drive_d(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 5'd31, 5'd31, 5'd31);
    tick();
    check("invalid_e", e_vec(), 64'd0);
    idle_d();
    repeat (3) tick();

    // Counter wraps at 2^RW.
    reset = 1'b1;
    sb.delete();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 17; i++) begin
      drive_d(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 5'd1, 5'd2, 5'(i));
      tick();
    end
    idle_d();
    repeat (4) tick();
    check("wrap_retire", 64'(RetireCount), 64'd1);

    // Asynchronous reset with three instructions in flight.
    for (int i = 0; i < 3; i++) begin
      drive_d(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 5'd1, 5'(16 + i), 5'd0);
      tick();
    end
    idle_d();
    #3;
    reset = 1'b1;
    sb.delete();
    #1;
    check("async_reset", all_out(), 64'd0);
    tick();
    reset = 1'b0;
    repeat (4) tick();
    check("final_idle", all_out(), 64'd0);
    check("sb_drain", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
